jelly2_communication_mailbox: RTL and testbench
===============================================

// Module: jelly2_communication_mailbox
// PURPOSE
//  Multi-channel software mailbox: NUM independent FIFO channels behind one Wishbone slave.
//  Adds per-channel programmable IRQ thresholds, FIFO flush, status/count readback and a bus-safe decode.
//  Sits between CPU cores sharing a WB bus as the next-generation inter-core pipe block.
// PARAMETERS
//  NUM            4             number of channels (1..2**(WB_ADR_WIDTH-SUB_ADR_WIDTH))
//  CORE_ID        32'h527a_f102 value of ID register
//  CORE_VERSION   32'h0002_0000 value of VERSION register
//  DATA_WIDTH     8             FIFO word width (<= WB_DAT_WIDTH)
//  FIFO_PTR_WIDTH 6             FIFO depth = 2**FIFO_PTR_WIDTH per channel
//  FIFO_RAM_TYPE  "distributed" RAM style attribute for FIFO storage
//  SUB_ADR_WIDTH  4             word-address bits per channel window
//  WB_ADR_WIDTH   8             word-address width; upper bits select channel
//  WB_DAT_WIDTH   32            bus data width; WB_SEL_WIDTH = WB_DAT_WIDTH/8
// PORTS
//  s_wb_clk_i  in  1                  the single clock
//  s_wb_rst_i  in  1                  reset, asynchronous, active-high
//  s_wb_adr_i  in  WB_ADR_WIDTH       word address {channel, sub_adr}
//  s_wb_dat_i  in  WB_DAT_WIDTH       write data
//  s_wb_dat_o  out WB_DAT_WIDTH       read data, registered
//  s_wb_we_i   in  1                  write enable
//  s_wb_sel_i  in  WB_SEL_WIDTH       byte select; any nonzero bit = full-word write
//  s_wb_stb_i  in  1                  strobe, held by master until ack
//  s_wb_ack_o  out 1                  ack, registered single-cycle pulse
//  irq_tx      out NUM                per-channel TX-space interrupt (level)
//  irq_rx      out NUM                per-channel RX-data interrupt (level)
//  irq_any     out 1                  OR of all irq_tx/irq_rx
// BEHAVIOUR
//  Reset: s_wb_ack_o=0, s_wb_dat_o=0, all FIFOs empty (ptrs=0), IRQ_ENABLE=0, RX_THRESH=1, TX_THRESH=1.
//  Bus: on posedge with stb=1 & ack=0 -> access executes, ack=1 next cycle with dat_o valid; ack then drops.
//   Latency 1 cycle; back-to-back = one access per 2 cycles. stb dropped before ack -> no side effects.
//  Channel ch = adr[WB_ADR_WIDTH-1:SUB_ADR_WIDTH]; ch >= NUM -> acked, dat_o=0, writes ignored (no hang).
//  Sub-register map (word address): 0 ID(R) 1 VERSION(R) 2 SERIAL=ch(R) 4 DATA(W push/R pop)
//   5 STATUS(R){..,full,empty} 6 COUNT(R) 7 FREE(R) 8 IRQ_ENABLE(RW){rx,tx} 9 IRQ_STATUS(R){rx,tx}
//   10 RX_THRESH(RW) 11 TX_THRESH(RW) 12 CLEAR(W bit0=1 flushes FIFO); unmapped: read 0, write ignored.
//  Per-channel storage: wr_ptr/rd_ptr of FIFO_PTR_WIDTH+1 bits, natural wrap; COUNT=wr_ptr-rd_ptr;
//   FREE=2**FIFO_PTR_WIDTH-COUNT; full when COUNT==depth, empty when COUNT==0.
//  Push: writes s_wb_dat_i[DATA_WIDTH-1:0]; dropped when full (ptrs unchanged).
//  Pop: dat_o = zero-extended mem[rd_ptr], rd_ptr++; when empty dat_o=0, ptrs unchanged.
//  CLEAR: rd_ptr<=wr_ptr in the access cycle; thresholds/enables kept.
//  Thresholds are FIFO_PTR_WIDTH+1 bits, wider writes truncated.
//  IRQ_STATUS.rx = COUNT>=RX_THRESH & COUNT!=0; IRQ_STATUS.tx = FREE>=TX_THRESH.
//  irq_rx[ch]=status.rx & en.rx, irq_tx[ch]=status.tx & en.tx, combinational from registered state,
//   updated the cycle after the push/pop/clear takes effect.
//  Reset asserted mid-access: ack and dat_o clear immediately; pending access is lost.
// CONFIGURATION
//  JELLY2_COMMUNICATION_MAILBOX_ERR_EN defined: per-channel sticky flags overflow (push when full)
//   and underflow (pop when empty) in STATUS bits 2 and 3; write 1 to sub-addr 13 clears the
//   corresponding bit (bit0=ovf, bit1=udf); flags reset to 0.
//  Not defined: STATUS bits 2/3 read 0, sub-addr 13 unmapped, drop/zero behaviour unchanged.
// TESTING
//  Reset, read ch0 adr 0/1/2 -> 32'h527a_f102, 32'h0002_0000, 0; ch2 SERIAL -> 2; ack each 1 cycle.
//  Push 0x11,0x22,0x33 to ch1, pop x3 -> 0x11,0x22,0x33, 4th pop -> 0, COUNT 0, empty=1.
//  Fill ch0 with 64 words (PTR=6) -> full=1, FREE=0; push 0xAA dropped; pop all in order; repeat
//   fill/drain twice to cross pointer wrap.
//  ch3 RX_THRESH=4, IRQ_ENABLE=2'b10: 3 pushes -> irq_rx[3]=0, 4th -> irq_rx[3]=1, irq_any=1;
//   one pop -> 0; TX_THRESH=64 en tx -> irq_tx[3]=1 only when COUNT=0.
//  Access ch=NUM (adr 8'h40) read/write -> ack in 1 cycle, dat_o=0, no channel state changes.
//  Push 5 to ch1, CLEAR -> COUNT=0; with ERR_EN: push when full -> STATUS[2]=1, W1C at 13 -> 0.

Source files
------------

// File: rtl/jelly2_communication_mailbox.sv
// Multi-channel mailbox: NUM independent FIFO channels behind one Wishbone slave.
// Each channel owns a word window of 2**SUB_ADR_WIDTH registers selected by the
// upper address bits. Optional error flags: define JELLY2_COMMUNICATION_MAILBOX_ERR_EN
// to add sticky overflow/underflow bits in STATUS and a W1C register at sub-address 13.
module jelly2_communication_mailbox #(
  parameter int          NUM            = 4,
  parameter logic [31:0] CORE_ID        = 32'h527a_f102,
  parameter logic [31:0] CORE_VERSION   = 32'h0002_0000,
  parameter int          DATA_WIDTH     = 8,
  parameter int          FIFO_PTR_WIDTH = 6,
  parameter              FIFO_RAM_TYPE  = "distributed",
  parameter int          SUB_ADR_WIDTH  = 4,
  parameter int          WB_ADR_WIDTH   = 8,
  parameter int          WB_DAT_WIDTH   = 32
) (
  input  logic                      s_wb_clk_i,
  input  logic                      s_wb_rst_i,
  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic                      s_wb_we_i,
  input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,
  output logic [NUM-1:0]            irq_tx,
  output logic [NUM-1:0]            irq_rx,
  output logic                      irq_any
);

  localparam int CH_WIDTH = WB_ADR_WIDTH - SUB_ADR_WIDTH;
  localparam int CH_IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int PW       = FIFO_PTR_WIDTH;
  localparam int DEPTH    = 2 ** PW;

  typedef logic [PW:0]               ptr_t;
  typedef logic [SUB_ADR_WIDTH-1:0]  sub_t;

  localparam sub_t ADR_ID      = sub_t'(0);
  localparam sub_t ADR_VERSION = sub_t'(1);
  localparam sub_t ADR_SERIAL  = sub_t'(2);
  localparam sub_t ADR_DATA    = sub_t'(4);
  localparam sub_t ADR_STATUS  = sub_t'(5);
  localparam sub_t ADR_COUNT   = sub_t'(6);
  localparam sub_t ADR_FREE    = sub_t'(7);
  localparam sub_t ADR_IRQ_EN  = sub_t'(8);
  localparam sub_t ADR_IRQ_ST  = sub_t'(9);
  localparam sub_t ADR_RX_TH   = sub_t'(10);
  localparam sub_t ADR_TX_TH   = sub_t'(11);
  localparam sub_t ADR_CLEAR   = sub_t'(12);
`ifdef JELLY2_COMMUNICATION_MAILBOX_ERR_EN
  localparam sub_t ADR_ERR_CLR = sub_t'(13);
`endif

  // Per-channel state
  ptr_t       wr_ptr_q [NUM];
  ptr_t       rd_ptr_q [NUM];
  logic [1:0] irq_en_q [NUM];   // {rx, tx}
  ptr_t       rx_th_q  [NUM];
  ptr_t       tx_th_q  [NUM];
`ifdef JELLY2_COMMUNICATION_MAILBOX_ERR_EN
  logic       ovf_q    [NUM];
  logic       udf_q    [NUM];
`endif

  (* ram_style = FIFO_RAM_TYPE *)
  logic [DATA_WIDTH-1:0] mem_q [NUM][DEPTH];

  logic                    ack_q;
  logic [WB_DAT_WIDTH-1:0] dat_q;

  // Derived per-channel levels
  ptr_t       count [NUM];
  ptr_t       free  [NUM];
  logic       empty [NUM];
  logic       full  [NUM];
  logic [1:0] irq_st[NUM];      // {rx, tx}

  // Address decode
  logic [CH_WIDTH-1:0] ch_sel;
  logic [CH_IDX_W-1:0] ch;
  sub_t                sub_adr;
  logic                ch_ok;
  logic                acc;
  logic                wr;
  logic                push;
  logic                pop;
  logic [WB_DAT_WIDTH-1:0] rd_data;

  assign ch_sel  = s_wb_adr_i[WB_ADR_WIDTH-1:SUB_ADR_WIDTH];
  assign sub_adr = s_wb_adr_i[SUB_ADR_WIDTH-1:0];
  assign ch      = CH_IDX_W'(ch_sel);
  assign ch_ok   = ({1'b0, ch_sel} < (CH_WIDTH+1)'(NUM));
  assign acc     = s_wb_stb_i & ~ack_q;
  assign wr      = s_wb_we_i & (|s_wb_sel_i);
  assign push    = acc & ch_ok & wr & (sub_adr == ADR_DATA);
  assign pop     = acc & ch_ok & ~s_wb_we_i & (sub_adr == ADR_DATA);

  assign s_wb_ack_o = ack_q;
  assign s_wb_dat_o = dat_q;

  // Occupancy, interrupt status and interrupt lines from registered state
  always_comb begin
    irq_tx = '0;
    irq_rx = '0;
    for (int i = 0; i < NUM; i++) begin
      count[i]     = wr_ptr_q[i] - rd_ptr_q[i];
      free[i]      = ptr_t'(DEPTH) - count[i];
      empty[i]     = (count[i] == '0);
      full[i]      = (count[i] == ptr_t'(DEPTH));
      irq_st[i][1] = (count[i] >= rx_th_q[i]) && !empty[i];
      irq_st[i][0] = (free[i] >= tx_th_q[i]);
      irq_rx[i]    = irq_st[i][1] & irq_en_q[i][1];
      irq_tx[i]    = irq_st[i][0] & irq_en_q[i][0];
    end
  end

  assign irq_any = (|irq_tx) | (|irq_rx);

  // Read-data multiplexer for the addressed register
  always_comb begin
    rd_data = '0;
    if (ch_ok) begin
      case (sub_adr)
        ADR_ID:      rd_data = WB_DAT_WIDTH'(CORE_ID);
        ADR_VERSION: rd_data = WB_DAT_WIDTH'(CORE_VERSION);
        ADR_SERIAL:  rd_data = WB_DAT_WIDTH'(ch_sel);
        ADR_DATA:    if (!empty[ch]) rd_data = WB_DAT_WIDTH'(mem_q[ch][rd_ptr_q[ch][PW-1:0]]);
        ADR_STATUS: begin
          rd_data[0] = empty[ch];
          rd_data[1] = full[ch];
`ifdef JELLY2_COMMUNICATION_MAILBOX_ERR_EN
          rd_data[2] = ovf_q[ch];
          rd_data[3] = udf_q[ch];
`endif
        end
        ADR_COUNT:   rd_data = WB_DAT_WIDTH'(count[ch]);
        ADR_FREE:    rd_data = WB_DAT_WIDTH'(free[ch]);
        ADR_IRQ_EN:  rd_data = WB_DAT_WIDTH'(irq_en_q[ch]);
        ADR_IRQ_ST:  rd_data = WB_DAT_WIDTH'(irq_st[ch]);
        ADR_RX_TH:   rd_data = WB_DAT_WIDTH'(rx_th_q[ch]);
        ADR_TX_TH:   rd_data = WB_DAT_WIDTH'(tx_th_q[ch]);
        default:     rd_data = '0;
      endcase
    end
  end

  // FIFO storage write port
  // NOTE: the storage array has no reset so it can map onto RAM; the pointers alone define validity.
  always_ff @(posedge s_wb_clk_i) begin
    if (push && !full[ch]) begin
      mem_q[ch][wr_ptr_q[ch][PW-1:0]] <= s_wb_dat_i[DATA_WIDTH-1:0];
    end
  end

  // Bus handshake, register writes and FIFO pointer updates
  always_ff @(posedge s_wb_clk_i or posedge s_wb_rst_i) begin
    if (s_wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      for (int i = 0; i < NUM; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        irq_en_q[i] <= '0;
        rx_th_q[i]  <= ptr_t'(1);
        tx_th_q[i]  <= ptr_t'(1);
`ifdef JELLY2_COMMUNICATION_MAILBOX_ERR_EN
        ovf_q[i]    <= 1'b0;
        udf_q[i]    <= 1'b0;
`endif
      end
    end else begin
      ack_q <= acc;
      if (acc) dat_q <= s_wb_we_i ? '0 : rd_data;

      if (acc && ch_ok && wr) begin
        case (sub_adr)
          ADR_DATA: begin
            if (!full[ch]) wr_ptr_q[ch] <= wr_ptr_q[ch] + ptr_t'(1);
`ifdef JELLY2_COMMUNICATION_MAILBOX_ERR_EN
            else           ovf_q[ch]    <= 1'b1;
`endif
          end
          ADR_IRQ_EN: irq_en_q[ch] <= s_wb_dat_i[1:0];
          ADR_RX_TH:  rx_th_q[ch]  <= s_wb_dat_i[PW:0];
          ADR_TX_TH:  tx_th_q[ch]  <= s_wb_dat_i[PW:0];
          ADR_CLEAR:  if (s_wb_dat_i[0]) rd_ptr_q[ch] <= wr_ptr_q[ch];
`ifdef JELLY2_COMMUNICATION_MAILBOX_ERR_EN
          ADR_ERR_CLR: begin
            if (s_wb_dat_i[0]) ovf_q[ch] <= 1'b0;
            if (s_wb_dat_i[1]) udf_q[ch] <= 1'b0;
          end
`endif
          default: ;
        endcase
      end

      if (pop) begin
        if (!empty[ch]) rd_ptr_q[ch] <= rd_ptr_q[ch] + ptr_t'(1);
`ifdef JELLY2_COMMUNICATION_MAILBOX_ERR_EN
        else            udf_q[ch]    <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_jelly2_communication_mailbox.sv
// Self-checking bench for jelly2_communication_mailbox (default parameters).
// Expected read data is queued when an access is issued and compared on ack;
// FIFO contents are tracked by a reference queue.
module tb_jelly2_communication_mailbox;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic        stb_i = 1'b0;
  logic        ack_o;
  logic [3:0]  irq_tx;
  logic [3:0]  irq_rx;
  logic        irq_any;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mdl[$];

  jelly2_communication_mailbox dut (
    .s_wb_clk_i (clk),
    .s_wb_rst_i (rst),
    .s_wb_adr_i (adr_i),
    .s_wb_dat_i (dat_i),
    .s_wb_dat_o (dat_o),
    .s_wb_we_i  (we_i),
    .s_wb_sel_i (sel_i),
    .s_wb_stb_i (stb_i),
    .s_wb_ack_o (ack_o),
    .irq_tx     (irq_tx),
    .irq_rx     (irq_rx),
    .irq_any    (irq_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] a(input int ch, input int sub);
    a = 8'((ch << 4) | sub);
  endfunction

  // One Wishbone access; checks single-cycle ack and that ack is a pulse
  task automatic wb_xfer(input logic [7:0] adr, input logic we, input logic [31:0] dat,
                         output logic [31:0] rdata);
    int cyc;
    @(negedge clk);
    adr_i = adr; we_i = we; dat_i = dat; sel_i = 4'hf; stb_i = 1'b1;
    @(posedge clk); #1;
    check("ack_latency", 32'(ack_o), 32'd1);
    cyc = 0;
    while (!ack_o && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!ack_o) check("ack_timeout", 32'(ack_o), 32'd1);
    rdata = dat_o;
    stb_i = 1'b0; we_i = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", 32'(ack_o), 32'd0);
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    wb_xfer(adr, 1'b1, dat, rd);
  endtask

  task automatic rd_expect(input string tag, input logic [7:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    exp_q.push_back(exp);
    wb_xfer(adr, 1'b0, '0, rd);
    check(tag, rd, exp_q.pop_front());
  endtask

  // Push to a channel, mirroring the drop-when-full rule in the model
  task automatic push(input int ch, input logic [7:0] d);
    if (mdl.size() < DEPTH) mdl.push_back(d);
    wr(a(ch, 4), {24'h00abcd, d});
  endtask

  // Pop from a channel; the model supplies the expected word (0 when empty)
  task automatic pop(input string tag, input int ch);
    logic [31:0] e;
    e = (mdl.size() > 0) ? 32'(mdl.pop_front()) : 32'd0;
    rd_expect(tag, a(ch, 4), e);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", {30'd0, irq_any, |{irq_tx, irq_rx}}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Identification
    rd_expect("id",      a(0, 0), 32'h527a_f102);
    rd_expect("version", a(0, 1), 32'h0002_0000);
    rd_expect("serial0", a(0, 2), 32'd0);
    rd_expect("serial2", a(2, 2), 32'd2);
    rd_expect("unmapped3", a(0, 3), 32'd0);
    rd_expect("rst_rxth", a(2, 10), 32'd1);
    rd_expect("rst_txth", a(2, 11), 32'd1);

    // Basic FIFO on ch1 including pop-when-empty
    push(1, 8'h11); push(1, 8'h22); push(1, 8'h33);
    rd_expect("ch1_count3", a(1, 6), 32'd3);
    for (int i = 0; i < 4; i++) pop("ch1_pop", 1);
    rd_expect("ch1_count0", a(1, 6), 32'd0);
    begin
      logic [31:0] rd;
      wb_xfer(a(1, 5), 1'b0, '0, rd);
      check("ch1_empty", {30'd0, rd[1:0]}, 32'd1);
    end

    // Fill/drain ch0 three times to cross the pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) push(0, 8'((r * 64 + i) ^ 8'h5a));
      rd_expect("ch0_count_full", a(0, 6), 32'd64);
      rd_expect("ch0_free_full",  a(0, 7), 32'd0);
      begin
        logic [31:0] rd;
        wb_xfer(a(0, 5), 1'b0, '0, rd);
        check("ch0_status_full", {30'd0, rd[1:0]}, 32'd2);
      end
      push(0, 8'haa);
      rd_expect("ch0_count_drop", a(0, 6), 32'd64);
      for (int i = 0; i < DEPTH; i++) pop("ch0_pop", 0);
      rd_expect("ch0_free_empty", a(0, 7), 32'd64);
    end

    // Interrupts on ch3
    wr(a(3, 10), 32'd4);
    wr(a(3, 8), 32'd2);
    for (int i = 0; i < 3; i++) push(3, 8'(8'h30 + i));
    check("irq_rx_below", 32'(irq_rx), 32'd0);
    push(3, 8'h33);
    check("irq_rx_at", 32'(irq_rx), 32'b1000);
    check("irq_any_rx", 32'(irq_any), 32'd1);
    rd_expect("irq_status", a(3, 9), 32'd3);
    pop("ch3_pop", 3);
    check("irq_rx_after_pop", 32'(irq_rx), 32'd0);
    check("irq_any_clear", 32'(irq_any), 32'd0);
    wr(a(3, 11), 32'h0000_01c0);
    rd_expect("txth_trunc", a(3, 11), 32'h40);
    wr(a(3, 8), 32'd3);
    rd_expect("irq_en_rb", a(3, 8), 32'd3);
    check("irq_tx_count3", 32'(irq_tx), 32'd0);
    pop("ch3_pop", 3); pop("ch3_pop", 3);
    check("irq_tx_count1", 32'(irq_tx), 32'd0);
    pop("ch3_pop", 3);
    check("irq_tx_empty", 32'(irq_tx), 32'b1000);
    check("irq_rx_empty", 32'(irq_rx), 32'd0);
    check("irq_any_tx", 32'(irq_any), 32'd1);
    wr(a(3, 8), 32'd0);

    // Channel index out of range
    rd_expect("oob_id", 8'h40, 32'd0);
    wr(8'h44, 32'h77);
    wr(8'h4a, 32'h9);
    rd_expect("oob_data", 8'h44, 32'd0);
    rd_expect("oob_ch0_count", a(0, 6), 32'd0);
    rd_expect("oob_ch0_rxth",  a(0, 10), 32'd1);

    // CLEAR keeps thresholds
    for (int i = 0; i < 5; i++) push(1, 8'(i + 1));
    rd_expect("ch1_count5", a(1, 6), 32'd5);
    wr(a(1, 12), 32'd1);
    mdl.delete();
    rd_expect("clear_count", a(1, 6), 32'd0);
    rd_expect("clear_keep_th", a(3, 10), 32'd4);
    push(1, 8'h66);
    pop("ch1_after_clear", 1);

`ifdef JELLY2_COMMUNICATION_MAILBOX_ERR_EN
    // ch0 overflowed during the fill rounds, ch1 underflowed on its 4th pop
    rd_expect("ch0_ovf", a(0, 5), 32'h5);
    wr(a(0, 13), 32'd1);
    rd_expect("ch0_ovf_w1c", a(0, 5), 32'h1);
    rd_expect("ch1_udf", a(1, 5), 32'h9);
    wr(a(1, 13), 32'd2);
    rd_expect("ch1_udf_w1c", a(1, 5), 32'h1);
`else
    rd_expect("ch0_status_noerr", a(0, 5), 32'h1);
    rd_expect("ch1_status_noerr", a(1, 5), 32'h1);
    rd_expect("sub13_unmapped", a(0, 13), 32'd0);
`endif

    // Reset in the middle of an access
    push(2, 8'h99);
    @(negedge clk);
    adr_i = a(0, 0); we_i = 1'b0; sel_i = 4'hf; stb_i = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_ack", 32'(ack_o), 32'd1);
    check("pre_rst_dat", dat_o, 32'h527a_f102);
    rst = 1'b1;
    #1;
    check("mid_rst_ack", 32'(ack_o), 32'd0);
    check("mid_rst_dat", dat_o, 32'd0);
    stb_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    mdl.delete();
    rd_expect("post_rst_count", a(2, 6), 32'd0);
    rd_expect("post_rst_rxth",  a(3, 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
